// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Brief    : Shared slice width, FSM state type and width check for the
//            sliced wide adder.
// Revision : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit width_ok(input int width, input int slice);
        return (slice > 0) && (width >= slice) && ((width % slice) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/slice_csel_add.sv
`default_nettype none
// ============================================================================
// Module   : slice_csel_add
// Brief    : Combinational W-bit carry-select adder: low half ripples from
//            c_in, high half is precomputed for both carries and muxed.
// Revision : 1.0 - initial release
// ============================================================================
module slice_csel_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out
);

    localparam int LO_W = W / 2;
    localparam int HI_W = W - LO_W;

    function automatic logic [LO_W:0] ripple_lo(input logic [LO_W-1:0] x,
                                                input logic [LO_W-1:0] y,
                                                input logic            ci);
        logic [LO_W:0] r;
        logic          c;
        r = '0;
        c = ci;
        for (int i = 0; i < LO_W; i++) begin
            r[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        r[LO_W] = c;
        return r;
    endfunction

    function automatic logic [HI_W:0] ripple_hi(input logic [HI_W-1:0] x,
                                                input logic [HI_W-1:0] y,
                                                input logic            ci);
        logic [HI_W:0] r;
        logic          c;
        r = '0;
        c = ci;
        for (int i = 0; i < HI_W; i++) begin
            r[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        r[HI_W] = c;
        return r;
    endfunction

    logic [LO_W:0] w_lo;
    logic [HI_W:0] w_hi0;
    logic [HI_W:0] w_hi1;
    logic [HI_W:0] w_hi_sel;

    assign w_lo  = ripple_lo(a[LO_W-1:0], b[LO_W-1:0], c_in);
    assign w_hi0 = ripple_hi(a[W-1:LO_W], b[W-1:LO_W], 1'b0);
    assign w_hi1 = ripple_hi(a[W-1:LO_W], b[W-1:LO_W], 1'b1);

    // Low-half carry picks which speculative high half is real
    assign w_hi_sel = w_lo[LO_W] ? w_hi1 : w_hi0;

    assign sum   = {w_hi_sel[HI_W-1:0], w_lo[LO_W-1:0]};
    assign c_out = w_hi_sel[HI_W];

endmodule
`default_nettype wire

// File: rtl/sliced_wide_adder.sv
`default_nettype none
// ============================================================================
// Module   : sliced_wide_adder
// Brief    : Multi-cycle WIDTH-bit add/subtract streaming one SLICE-bit chunk
//            per clock through a single carry-select slice.
// Revision : 1.0 - initial release
// ============================================================================
module sliced_wide_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NSLICE - 1);

    generate
        if (!width_ok(WIDTH, SLICE)) begin : g_bad_width
            $error("sliced_wide_adder: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_sum;
    logic               r_c_out;
    logic               r_ovf;

    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic [SLICE-1:0]   w_s;
    logic               w_co;

    assign w_a_slice = r_a[r_idx*SLICE +: SLICE];
    assign w_b_slice = r_b[r_idx*SLICE +: SLICE];

    slice_csel_add #(
        .W     (SLICE)
    ) u_slice (
        .a     (w_a_slice),
        .b     (w_b_slice),
        .c_in  (r_carry),
        .sum   (w_s),
        .c_out (w_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is a + ~b + 1; c_in is ignored then
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : c_in;
                        r_idx   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_idx*SLICE +: SLICE] <= w_s;
                    r_carry <= w_co;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == C_LAST_IDX) begin
                        r_c_out <= w_co;
                        r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                   (w_s[SLICE-1] != r_a[WIDTH-1]);
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: doc/sliced_wide_adder.md
Name: sliced_wide_adder

Overview:
Multi-cycle WIDTH-bit add/subtract unit that sits upstream of the 8-bit carry-select adder slice. It streams one SLICE-bit chunk per clock through that slice and registers the inter-slice carry. It assembles the full result and returns it over a valid/ready handshake. This gives the ALU wide adds at 8-bit slice area cost.

Parameters:
WIDTH, 32, operand/result width; must be a multiple of SLICE (elaboration error otherwise)
SLICE, 8, bits processed per cycle
NSLICE, WIDTH/SLICE, derived localparam; number of slice cycles per operation

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operand request
in_ready  out  1  block can accept an operand; high only in IDLE
a  in  WIDTH  operand A
b  in  WIDTH  operand B
c_in  in  1  carry-in; used only when sub=0
sub  in  1  1 = compute a - b
out_valid  out  1  result available; high only in DONE
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result register
c_out  out  1  final carry; for sub, 1 = no borrow
ovf  out  1  two's-complement signed overflow
busy  out  1  high in RUN or DONE

Behaviour:
- Reset: when rst=1 at a clock edge, state goes to IDLE and every register clears.
  - After that edge: sum=0, c_out=0, ovf=0, out_valid=0, busy=0, in_ready=1.
  - rst takes priority over all other inputs. A reset mid-operation aborts the operation; no out_valid is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge:
    - latch a_r=a;
    - latch b_r = sub ? ~b : b;
    - carry_r = sub ? 1 : c_in;
    - idx=0;
    - go to RUN.
- RUN:
  - Each cycle, slice idx computes {co, s} = a_r[idx] + b_r[idx] + carry_r.
  - At the edge: sum[idx*SLICE +: SLICE] gets s, carry_r gets co, idx increments.
  - When idx == NSLICE-1, the same edge also sets c_out=co, sets ovf, and moves to DONE.
  - in_ready=0. in_valid is ignored.
- ovf = (a_r[MSB] == b_r[MSB]) && (sum[MSB] != a_r[MSB]), evaluated on the final slice result.
- DONE:
  - out_valid=1.
  - sum, c_out and ovf are stable.
  - When out_ready=1 at an edge, go to IDLE. out_valid drops in the next cycle.
- Latency: out_valid first rises NSLICE cycles after the accepting edge (4 for WIDTH=32).
- Minimum issue interval: NSLICE+2 cycles. There is no overlap between operations.
- sum holds its last value in IDLE until the next accept. Upper bits are stale during RUN and carry no meaning.
- Arithmetic is modulo 2^WIDTH. The carry out of the top slice goes only to c_out.
- With NSLICE=1, RUN lasts exactly one cycle.
- in_valid and out_ready are never both acted on in the same cycle, because their states are disjoint.

Decomposition:
- Shared package adder_pkg holds:
  - SLICE_W = 8 constant;
  - state enum typedef {IDLE, RUN, DONE};
  - a width-check function for WIDTH % SLICE.
- One sub-module: slice_csel_add, a combinational SLICE-bit carry-select add (two half-slice ripple adders plus carry-select mux).
  - Ports: a, b, c_in, sum, c_out.
  - The team's existing 8-bit carry-select adder satisfies this interface when SLICE=8.
- The index counter, carry register, FSM and handshake stay in the top module.

Test Plan:
- WIDTH=32, a=0x000000FF, b=0x00000001, c_in=0, sub=0 -> out_valid exactly 4 cycles after accept; sum=0x00000100, c_out=0, ovf=0.
- a=0xFFFFFFFF, b=0x00000001, c_in=0 -> sum=0x00000000, c_out=1, ovf=0 (carry crosses all 4 slices). Repeat with c_in=1, b=0 -> same result.
- a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, ovf=1, c_out=0. Also a=0x80000000, b=0x80000000 -> sum=0, c_out=1, ovf=1.
- sub=1, a=5, b=7 -> sum=0xFFFFFFFE, c_out=0, ovf=0. Then sub=1, a=7, b=5, c_in=1 -> sum=2, c_out=1 (c_in ignored).
- Hold out_ready=0 for 10 cycles in DONE while pulsing in_valid -> out_valid, sum, c_out and ovf stay constant; in_ready=0; no new accept. out_ready=1 -> IDLE the next cycle, in_ready=1.
- Assert rst for 1 cycle during the RUN slice idx=2 -> next cycle IDLE, in_ready=1, out_valid=0, sum=0; that operation never produces out_valid. A following op with a=1, b=2 returns sum=3.
